// File: rtl/chunked_addsub_pkg.sv
// ============================================================================
// Module      : chunked_addsub_pkg
// Description : Shared state encoding and result-flag record for the
//               chunked adder/subtractor.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package chunked_addsub_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    typedef struct packed {
        logic c;
        logic z;
        logic v;
    } flags_t;

    localparam flags_t c_FLAGS_RESET = '0;

endpackage

`default_nettype wire

// File: rtl/addsub_chunk.sv
// ============================================================================
// Module      : addsub_chunk
// Description : CHUNK-bit combinational full add with carry-in, carry-out and
//               the carry into the chunk MSB (for signed-overflow detection).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module addsub_chunk #(
    parameter int CHUNK = 8
) (
    input  logic [CHUNK-1:0] i_a,
    input  logic [CHUNK-1:0] i_b,
    input  logic             i_cin,
    output logic [CHUNK-1:0] o_s,
    output logic             o_cout,
    output logic             o_cmsb
);

    logic w_amsb;
    logic w_bmsb;

    assign w_amsb = i_a[CHUNK-1];
    assign w_bmsb = i_b[CHUNK-1];

    generate
        if (CHUNK == 1) begin : g_single
            assign o_cmsb = i_cin;
            assign o_s    = i_a ^ i_b ^ i_cin;
        end else begin : g_multi
            // Low CHUNK-1 bits summed separately so their carry is the MSB carry-in
            logic [CHUNK-1:0] w_low;
            assign w_low  = {1'b0, i_a[CHUNK-2:0]} + {1'b0, i_b[CHUNK-2:0]}
                          + {{(CHUNK-1){1'b0}}, i_cin};
            assign o_cmsb = w_low[CHUNK-1];
            assign o_s    = {w_amsb ^ w_bmsb ^ w_low[CHUNK-1], w_low[CHUNK-2:0]};
        end
    endgenerate

    assign o_cout = (w_amsb & w_bmsb) | (o_cmsb & (w_amsb ^ w_bmsb));

endmodule

`default_nettype wire

// File: rtl/chunked_addsub.sv
// ============================================================================
// Module      : chunked_addsub
// Description : Multi-cycle WIDTH-bit adder/subtractor, CHUNK bits per clock,
//               LS chunk first. Saturation enabled by CHUNKED_ADDSUB_SAT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module chunked_addsub
    import chunked_addsub_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CHUNK = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    input  logic             sat,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_s,
    output logic             out_c,
    output logic             zero,
    output logic             overflow
);

    localparam int               c_nchunk = WIDTH / CHUNK;
    localparam int               c_cw     = (c_nchunk > 1) ? $clog2(c_nchunk) : 1;
    localparam logic [c_cw-1:0]  c_last   = c_cw'(c_nchunk - 1);
    localparam logic [WIDTH-1:0] c_smax   = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] c_smin   = {1'b1, {(WIDTH-1){1'b0}}};

    state_t            state_q, state_d;
    logic [WIDTH-1:0]  a_q, a_d;
    logic [WIDTH-1:0]  b_q, b_d;
    logic [WIDTH-1:0]  s_q, s_d;
    logic              carry_q, carry_d;
    logic [c_cw-1:0]   count_q, count_d;
    flags_t            flags_q, flags_d;

    logic [CHUNK-1:0]  w_chunk_a;
    logic [CHUNK-1:0]  w_chunk_b;
    logic [CHUNK-1:0]  w_chunk_s;
    logic              w_cout;
    logic              w_cmsb;
    logic              w_ovf;
    logic              w_accept;
    logic [WIDTH-1:0]  w_merged;
    logic [WIDTH-1:0]  w_final;

    assign in_ready  = (state_q == IDLE) || ((state_q == DONE) && out_ready);
    assign w_accept  = in_valid && in_ready;
    assign out_valid = (state_q == DONE);
    assign out_s     = s_q;
    assign out_c     = flags_q.c;
    assign zero      = flags_q.z;
    assign overflow  = flags_q.v;
    assign w_ovf     = w_cmsb ^ w_cout;

    always_comb begin
        w_chunk_a = '0;
        w_chunk_b = '0;
        for (int k = 0; k < c_nchunk; k++) begin
            if (count_q == c_cw'(k)) begin
                w_chunk_a = a_q[k*CHUNK +: CHUNK];
                w_chunk_b = b_q[k*CHUNK +: CHUNK];
            end
        end
    end

    addsub_chunk #(
        .CHUNK (CHUNK)
    ) u_chunk (
        .i_a    (w_chunk_a),
        .i_b    (w_chunk_b),
        .i_cin  (carry_q),
        .o_s    (w_chunk_s),
        .o_cout (w_cout),
        .o_cmsb (w_cmsb)
    );

    always_comb begin
        w_merged = s_q;
        for (int k = 0; k < c_nchunk; k++) begin
            if (count_q == c_cw'(k)) begin
                w_merged[k*CHUNK +: CHUNK] = w_chunk_s;
            end
        end
    end

`ifdef CHUNKED_ADDSUB_SAT_EN
    logic sat_q, sat_d;

    // Carry-out set on overflow means both operands were negative
    always_comb begin
        w_final = w_merged;
        if (sat_q && w_ovf) begin
            w_final = w_cout ? c_smin : c_smax;
        end
    end

    always_comb begin
        sat_d = sat_q;
        if (w_accept) begin
            sat_d = sat;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sat_q <= 1'b0;
        end else begin
            sat_q <= sat_d;
        end
    end
`else
    logic w_unused_sat;

    assign w_unused_sat = sat;
    assign w_final      = w_merged;
`endif

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        s_d     = s_q;
        carry_d = carry_q;
        count_d = count_q;
        flags_d = flags_q;
        case (state_q)
            BUSY: begin
                s_d     = w_merged;
                carry_d = w_cout;
                count_d = (count_q == c_last) ? '0 : count_q + 1'b1;
                if (count_q == c_last) begin
                    s_d       = w_final;
                    flags_d.c = w_cout;
                    flags_d.z = (w_final == '0);
                    flags_d.v = w_ovf;
                    state_d   = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        // Accept may override DONE -> IDLE for back-to-back operation
        if (w_accept) begin
            a_d     = a;
            b_d     = b ^ {WIDTH{sub}};
            carry_d = sub;
            count_d = '0;
            state_d = BUSY;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            s_q     <= '0;
            carry_q <= 1'b0;
            count_q <= '0;
            flags_q <= c_FLAGS_RESET;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            s_q     <= s_d;
            carry_q <= carry_d;
            count_q <= count_d;
            flags_q <= flags_d;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_chunked_addsub.sv
// ============================================================================
// Module      : tb_chunked_addsub
// Description : Directed, table-driven bench for chunked_addsub (32/8), with
//               hand-written backpressure and mid-operation reset sequences.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_chunked_addsub;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] a;
    logic [31:0] b;
    logic        sub;
    logic        sat;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_s;
    logic        out_c;
    logic        zero;
    logic        overflow;

    int n_vec;
    int n_err;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        sub;
        logic        sat;
        logic [31:0] s;
        logic        c;
        logic        z;
        logic        v;
    } vec_t;

    vec_t vecs [12];

    chunked_addsub #(
        .WIDTH (32),
        .CHUNK (8)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .sub       (sub),
        .sat       (sat),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_s     (out_s),
        .out_c     (out_c),
        .zero      (zero),
        .overflow  (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, want %h", name, act, exp);
        end
    endtask

    task automatic wait_result(input string name);
        int cyc;
        cyc = 0;
        while (!out_valid && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        check({name, "/latency"}, 32'(cyc), 32'd4);
    endtask

    task automatic do_op(input string name, input vec_t v);
        @(negedge clk);
        a = v.a; b = v.b; sub = v.sub; sat = v.sat; in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        a = 32'hDEAD_BEEF; b = 32'hDEAD_BEEF;
        wait_result(name);
        check({name, "/s"}, out_s, v.s);
        check({name, "/c"}, {31'd0, out_c}, {31'd0, v.c});
        check({name, "/z"}, {31'd0, zero}, {31'd0, v.z});
        check({name, "/v"}, {31'd0, overflow}, {31'd0, v.v});
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        a = '0; b = '0; sub = 1'b0; sat = 1'b0;

        vecs[0]  = '{32'h0000_00FF, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0100, 1'b0, 1'b0, 1'b0};
        vecs[1]  = '{32'h0000_0005, 32'h0000_0005, 1'b1, 1'b0, 32'h0000_0000, 1'b1, 1'b1, 1'b0};
        vecs[2]  = '{32'h0000_0003, 32'h0000_0005, 1'b1, 1'b0, 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0};
        vecs[3]  = '{32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h8000_0000, 1'b0, 1'b0, 1'b1};
        vecs[4]  = '{32'h8000_0000, 32'h0000_0001, 1'b1, 1'b0, 32'h7FFF_FFFF, 1'b1, 1'b0, 1'b1};
        vecs[5]  = '{32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b1, 1'b0};
        vecs[6]  = '{32'h1234_5678, 32'h1111_1111, 1'b0, 1'b1, 32'h2345_6789, 1'b0, 1'b0, 1'b0};
        vecs[7]  = '{32'h0000_0000, 32'h0000_0001, 1'b1, 1'b0, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0};
        vecs[8]  = '{32'h00FF_00FF, 32'h0001_0001, 1'b0, 1'b0, 32'h0100_0100, 1'b0, 1'b0, 1'b0};
`ifdef CHUNKED_ADDSUB_SAT_EN
        vecs[9]  = '{32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b1, 32'h7FFF_FFFF, 1'b0, 1'b0, 1'b1};
        vecs[10] = '{32'h8000_0000, 32'h0000_0001, 1'b1, 1'b1, 32'h8000_0000, 1'b1, 1'b0, 1'b1};
        vecs[11] = '{32'h8000_0000, 32'h8000_0000, 1'b0, 1'b1, 32'h8000_0000, 1'b1, 1'b0, 1'b1};
`else
        vecs[9]  = '{32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b1, 32'h8000_0000, 1'b0, 1'b0, 1'b1};
        vecs[10] = '{32'h8000_0000, 32'h0000_0001, 1'b1, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b0, 1'b1};
        vecs[11] = '{32'h8000_0000, 32'h8000_0000, 1'b0, 1'b1, 32'h0000_0000, 1'b1, 1'b1, 1'b1};
`endif

        // Reset state, both during and after reset
        repeat (2) @(negedge clk);
        check("rst/in_ready",  {31'd0, in_ready},  32'd1);
        check("rst/out_valid", {31'd0, out_valid}, 32'd0);
        check("rst/out_s",     out_s,              32'd0);
        check("rst/out_c",     {31'd0, out_c},     32'd0);
        check("rst/zero",      {31'd0, zero},      32'd0);
        check("rst/overflow",  {31'd0, overflow},  32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("post_rst/in_ready",  {31'd0, in_ready},  32'd1);
        check("post_rst/out_valid", {31'd0, out_valid}, 32'd0);

        for (int i = 0; i < 12; i++) begin
            do_op($sformatf("vec%0d", i), vecs[i]);
        end

        // Backpressure: hold result 5 cycles, then consume + accept same edge
        @(negedge clk);
        a = 32'h7FFF_FFFF; b = 32'h0000_0001; sub = 1'b0; sat = 1'b0; in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        wait_result("bp");
        for (int i = 0; i < 5; i++) begin
            check("bp/out_valid", {31'd0, out_valid}, 32'd1);
            check("bp/in_ready",  {31'd0, in_ready},  32'd0);
            check("bp/out_s",     out_s,              32'h8000_0000);
            check("bp/overflow",  {31'd0, overflow},  32'd1);
            check("bp/out_c",     {31'd0, out_c},     32'd0);
            @(negedge clk);
        end
        a = 32'h0000_00FF; b = 32'h0000_0001; sub = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
        #1;
        check("b2b/in_ready", {31'd0, in_ready}, 32'd1);
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0; out_ready = 1'b0;
        check("b2b/out_valid_low", {31'd0, out_valid}, 32'd0);
        wait_result("b2b");
        check("b2b/out_s",    out_s,              32'h0000_0100);
        check("b2b/overflow", {31'd0, overflow},  32'd0);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;

        // Reset during the second BUSY cycle
        @(negedge clk);
        a = 32'h0000_00F0; b = 32'h0000_000F; sub = 1'b0; in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst/out_valid", {31'd0, out_valid}, 32'd0);
        check("midrst/in_ready",  {31'd0, in_ready},  32'd1);
        check("midrst/out_s",     out_s,              32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("midrst/in_ready_after", {31'd0, in_ready}, 32'd1);
        do_op("after_rst", '{32'h1234_5678, 32'h1111_1111, 1'b0, 1'b0,
                             32'h2345_6789, 1'b0, 1'b0, 1'b0});

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
